// File: rtl/branch_direction_predictor_pkg.sv
// Shared types and constants for the branch direction predictor:
// counter encoding, default geometry, FIFO entry layout and the
// saturating-counter update rule.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;  // strongly not-taken
    localparam ctr_t WNT = 2'b01;  // weakly not-taken
    localparam ctr_t WT  = 2'b10;  // weakly taken
    localparam ctr_t ST  = 2'b11;  // strongly taken

    localparam int   INDEX_BITS_DEFAULT  = 6;
    localparam int   QUEUE_DEPTH_DEFAULT = 3;
    localparam ctr_t CTR_RESET_DEFAULT   = WNT;

    // One in-flight branch: the table index it was predicted from and
    // the direction that was predicted.
    typedef struct packed {
        logic [INDEX_BITS_DEFAULT-1:0] idx;
        logic                          pred;
    } bp_entry_t;

    // Move a counter one step toward the resolved outcome, saturating at
    // ST for taken and SNT for not-taken.
    function automatic ctr_t ctr_train(input ctr_t c, input logic taken);
        ctr_t r;
        r = c;
        if (taken && c != ST) begin
            r = c + 2'd1;
        end else if (!taken && c != SNT) begin
            r = c - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_direction_predictor_if.sv
// Fetch/queue-facing signal bundle of the branch direction predictor.
// master = fetch and resolution logic, slave = the predictor.
interface branch_direction_predictor_if;
    logic        stall;
    logic [15:0] pc;
    logic        is_branch;
    logic [15:0] branch_target;
    logic        prediction_in;
    logic [15:0] mispredict_address_in;
    logic        load;
    logic [15:0] predicted_pc;
    logic        full;
    logic        update;
    logic        correct;

    modport master (
        output stall, pc, is_branch, branch_target, update, correct,
        input  prediction_in, mispredict_address_in, load, predicted_pc, full
    );

    modport slave (
        input  stall, pc, is_branch, branch_target, update, correct,
        output prediction_in, mispredict_address_in, load, predicted_pc, full
    );
endinterface

// File: rtl/bp_sat_counter_table.sv
// Table of 2-bit saturating counters: one write port (training) and two
// combinational read ports (fetch lookup and head-of-FIFO training read).
module bp_sat_counter_table
    import bp_pkg::*;
#(
    parameter int   INDEX_BITS = INDEX_BITS_DEFAULT,
    parameter ctr_t CTR_RESET  = CTR_RESET_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] lookup_idx,
    output ctr_t                  lookup_ctr,
    input  logic [INDEX_BITS-1:0] train_idx,
    output ctr_t                  train_ctr,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  ctr_t                  wr_ctr
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    ctr_t table_q [ENTRIES];

    // Counter storage: every entry returns to CTR_RESET on reset so the
    // predictor restarts from a known bias; one counter written per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CTR_RESET;
            end
        end else if (wr_en) begin
            table_q[wr_idx] <= wr_ctr;
        end
    end

    // Reads see the registered table, so a same-cycle write is not visible.
    assign lookup_ctr = table_q[lookup_idx];
    assign train_ctr  = table_q[train_idx];

endmodule

// File: rtl/branch_direction_predictor.sv
// Fetch-stage 2-bit saturating-counter direction predictor. Drives the
// downstream branch queue (prediction_in, mispredict_address_in, load) and
// trains on the queue's update/correct resolution pulses, keeping a private
// in-order FIFO of {idx, pred} that mirrors the queue occupancy.
// Optional: define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history
// register into the table index. Define ASSERT_ON to flag update pulses
// that arrive with nothing in flight.
module branch_direction_predictor
    import bp_pkg::*;
#(
    parameter int   INDEX_BITS  = INDEX_BITS_DEFAULT,
    parameter int   QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT,
    parameter ctr_t CTR_RESET   = CTR_RESET_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    branch_direction_predictor_if.slave  bus
);

    localparam int                CW      = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW-1:0]     DEPTH_C = CW'(QUEUE_DEPTH);

    logic [INDEX_BITS-1:0] lookup_idx;
    ctr_t                  lookup_ctr;
    ctr_t                  head_ctr;
    logic                  taken;
    logic [15:0]           pc_plus2;

    bp_entry_t             fifo     [QUEUE_DEPTH];
    bp_entry_t             fifo_nxt [QUEUE_DEPTH];
    logic [CW-1:0]         count;
    logic [CW-1:0]         wr_slot;

    logic                  pop;
    logic                  mispredict;
    logic                  train_en;
    logic                  do_pop;
    logic                  do_push;
    logic                  flush;
    logic                  outcome;
    bp_entry_t             new_entry;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr;

    // Global history: newest resolved outcome enters at the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else if (train_en) begin
            ghr <= {ghr[INDEX_BITS-2:0], outcome};
        end
    end

    assign lookup_idx = bus.pc[INDEX_BITS:1] ^ ghr;
`else
    // PCs are 2-byte aligned, so bit 0 carries no information.
    assign lookup_idx = bus.pc[INDEX_BITS:1];
`endif

    bp_sat_counter_table #(
        .INDEX_BITS (INDEX_BITS),
        .CTR_RESET  (CTR_RESET)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .lookup_idx (lookup_idx),
        .lookup_ctr (lookup_ctr),
        .train_idx  (fifo[0].idx),
        .train_ctr  (head_ctr),
        .wr_en      (train_en),
        .wr_idx     (fifo[0].idx),
        .wr_ctr     (ctr_train(head_ctr, outcome))
    );

    // Zero-latency lookup and the resolution controls.
    assign taken      = lookup_ctr[1];
    assign pc_plus2   = bus.pc + 16'd2;
    assign pop        = bus.update & bus.correct & ~bus.stall;
    assign mispredict = bus.update & ~bus.correct & ~bus.stall;
    // An update with nothing in flight is ignored entirely.
    assign train_en   = bus.update & ~bus.stall & (count != '0);
    assign do_pop     = train_en & bus.correct;
    assign flush      = train_en & ~bus.correct;
    assign outcome    = bus.correct ? fifo[0].pred : ~fifo[0].pred;
    assign new_entry  = '{idx: lookup_idx, pred: taken};
    assign wr_slot    = do_pop ? count - 1'b1 : count;

    assign bus.full                  = (count == DEPTH_C);
    assign bus.prediction_in         = bus.is_branch & taken;
    assign bus.mispredict_address_in = taken ? pc_plus2 : bus.branch_target;
    assign bus.predicted_pc          = (bus.is_branch & taken) ? bus.branch_target : pc_plus2;
    // A redirect on mispredict means the current fetch is discarded.
    assign bus.load = bus.is_branch & ~bus.stall & (~bus.full | pop) & ~mispredict;
    assign do_push  = bus.load;

    // FIFO payload next state: shift down on pop, then write the new branch
    // behind the surviving entries.
    always_comb begin
        // NOTE: every target gets its default first so no path can infer a
        // latch; blocking '=' here, non-blocking '<=' only in always_ff.
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            fifo_nxt[i] = fifo[i];
        end
        if (do_pop) begin
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                fifo_nxt[i] = fifo[i + 1];
            end
        end
        if (do_push) begin
            fifo_nxt[wr_slot] = new_entry;
        end
    end

    // FIFO payload register.
    always_ff @(posedge clk) begin
        // NOTE: payload has no reset; count alone decides which slots are
        // valid, so stale contents are never observed.
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            fifo[i] <= fifo_nxt[i];
        end
    end

    // Occupancy: flush on mispredict, otherwise track push/pop balance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (do_push && !do_pop) begin
            count <= count + 1'b1;
        end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
        end
    end

`ifdef ASSERT_ON
    a_update_nonempty : assert property (
        @(posedge clk) disable iff (rst)
        (bus.update && !bus.stall) |-> (count != '0)
    ) else $error("update with no branch in flight");
`endif

endmodule

// File: tb/tb_branch_direction_predictor.sv
// Directed scoreboard bench for branch_direction_predictor (default build).
// Stimulus pushes hand-computed expectations into a queue; a monitor on the
// falling edge pops and compares against the DUT outputs.
module tb_branch_direction_predictor;

    logic clk;
    logic rst;

    branch_direction_predictor_if bus ();

    branch_direction_predictor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        pred;
        logic [15:0] mpa;
        logic        load;
        logic [15:0] ppc;
        logic        full;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    n_vec  = 0;
    int    n_miss = 0;

    // Monitor: compare whatever vector is pending, mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = '{pred: bus.prediction_in, mpa: bus.mispredict_address_in,
                  load: bus.load, ppc: bus.predicted_pc, full: bus.full};
            n_vec++;
            if (a !== e) begin
                n_miss++;
                $display("FAIL %s: got pred=%b mpa=%h load=%b ppc=%h full=%b, want pred=%b mpa=%h load=%b ppc=%h full=%b",
                         n, a.pred, a.mpa, a.load, a.ppc, a.full,
                         e.pred, e.mpa, e.load, e.ppc, e.full);
            end
        end
    end

    // Apply one vector just after the rising edge and queue its expectation.
    task automatic vec(input string n, input logic r, input logic st,
                       input logic [15:0] pc, input logic br, input logic [15:0] tgt,
                       input logic up, input logic cor,
                       input logic e_pred, input logic [15:0] e_mpa, input logic e_load,
                       input logic [15:0] e_ppc, input logic e_full);
        @(posedge clk);
        #1;
        rst               = r;
        bus.stall         = st;
        bus.pc            = pc;
        bus.is_branch     = br;
        bus.branch_target = tgt;
        bus.update        = up;
        bus.correct       = cor;
        exp_q.push_back('{pred: e_pred, mpa: e_mpa, load: e_load, ppc: e_ppc, full: e_full});
        name_q.push_back(n);
    endtask

    initial begin
        rst               = 1'b1;
        bus.stall         = 1'b0;
        bus.pc            = 16'h0000;
        bus.is_branch     = 1'b0;
        bus.branch_target = 16'h0000;
        bus.update        = 1'b0;
        bus.correct       = 1'b0;

        //   name              rst st  pc       br  tgt      up cor  pred mpa      load ppc      full
        vec("reset_state",     1, 0, 16'h0010, 0, 16'h0040, 0, 0,   0, 16'h0040, 0, 16'h0012, 0);
        vec("first_lookup",    0, 0, 16'h0010, 1, 16'h0040, 0, 0,   0, 16'h0040, 1, 16'h0012, 0);
        vec("mispredict",      0, 0, 16'h0010, 1, 16'h0040, 1, 0,   0, 16'h0040, 0, 16'h0012, 0);
        vec("refetch_taken",   0, 0, 16'h0010, 1, 16'h0040, 0, 0,   1, 16'h0012, 1, 16'h0040, 0);
        vec("fill2",           0, 0, 16'h0020, 1, 16'h0100, 0, 0,   0, 16'h0100, 1, 16'h0022, 0);
        vec("fill3",           0, 0, 16'h0030, 1, 16'h0200, 0, 0,   0, 16'h0200, 1, 16'h0032, 0);
        vec("full_hold",       0, 0, 16'h0040, 1, 16'h0300, 0, 0,   0, 16'h0300, 0, 16'h0042, 1);
        vec("full_pop_push",   0, 0, 16'h0040, 1, 16'h0300, 1, 1,   0, 16'h0300, 1, 16'h0042, 1);
        vec("full_after",      0, 0, 16'h0040, 0, 16'h0300, 0, 0,   0, 16'h0300, 0, 16'h0042, 1);
        vec("stall_freeze",    0, 1, 16'h0010, 1, 16'h0040, 1, 0,   1, 16'h0012, 0, 16'h0040, 1);
        vec("stall_after",     0, 0, 16'h0020, 0, 16'h0100, 0, 0,   0, 16'h0100, 0, 16'h0022, 1);
        vec("drain1",          0, 0, 16'h0010, 0, 16'h0040, 1, 1,   0, 16'h0012, 0, 16'h0012, 1);
        vec("drain2",          0, 0, 16'h0010, 0, 16'h0040, 1, 1,   0, 16'h0012, 0, 16'h0012, 0);
        vec("drain3",          0, 0, 16'h0010, 0, 16'h0040, 1, 1,   0, 16'h0012, 0, 16'h0012, 0);
        vec("sat_load",        0, 0, 16'h0010, 1, 16'h0040, 0, 0,   1, 16'h0012, 1, 16'h0040, 0);
        vec("sat_res1",        0, 0, 16'h0010, 1, 16'h0040, 1, 1,   1, 16'h0012, 1, 16'h0040, 0);
        vec("sat_res2",        0, 0, 16'h0010, 1, 16'h0040, 1, 1,   1, 16'h0012, 1, 16'h0040, 0);
        vec("sat_res3",        0, 0, 16'h0010, 1, 16'h0040, 1, 1,   1, 16'h0012, 1, 16'h0040, 0);
        vec("sat_res4",        0, 0, 16'h0010, 0, 16'h0040, 1, 1,   0, 16'h0012, 0, 16'h0012, 0);
        vec("sat_hold",        0, 0, 16'h0010, 1, 16'h0040, 0, 0,   1, 16'h0012, 1, 16'h0040, 0);
        vec("nt_resolve",      0, 0, 16'h0010, 0, 16'h0040, 1, 0,   0, 16'h0012, 0, 16'h0012, 0);
        vec("still_taken",     0, 0, 16'h0010, 1, 16'h0040, 0, 0,   1, 16'h0012, 1, 16'h0040, 0);
        vec("nt_resolve2",     0, 0, 16'h0010, 0, 16'h0040, 1, 0,   0, 16'h0012, 0, 16'h0012, 0);
        vec("now_not_taken",   0, 0, 16'h0010, 1, 16'h0040, 0, 0,   0, 16'h0040, 1, 16'h0012, 0);
        vec("rm_mispredict",   0, 0, 16'h0010, 0, 16'h0040, 1, 0,   0, 16'h0040, 0, 16'h0012, 0);
        vec("rm_load1",        0, 0, 16'h0010, 1, 16'h0040, 0, 0,   1, 16'h0012, 1, 16'h0040, 0);
        vec("rm_load2",        0, 0, 16'h0020, 1, 16'h0100, 0, 0,   0, 16'h0100, 1, 16'h0022, 0);
        vec("rst_async",       1, 0, 16'h0010, 0, 16'h0040, 0, 0,   0, 16'h0040, 0, 16'h0012, 0);
        vec("post_rst1",       0, 0, 16'h0010, 1, 16'h0040, 0, 0,   0, 16'h0040, 1, 16'h0012, 0);
        vec("post_rst2",       0, 0, 16'h0020, 1, 16'h0100, 0, 0,   0, 16'h0100, 1, 16'h0022, 0);
        vec("post_rst3",       0, 0, 16'h0030, 1, 16'h0200, 0, 0,   0, 16'h0200, 1, 16'h0032, 0);
        vec("post_rst_full",   0, 0, 16'h0030, 0, 16'h0200, 0, 0,   0, 16'h0200, 0, 16'h0032, 1);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
